// File: rtl/instr_encoder.sv
// RV32I field-to-word packer with a small output FIFO and a saturating pop counter.
// Optional immediate range flagging is enabled by defining INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [6:0]       opcode,
    input  logic [2:0]       func3,
    input  logic [6:0]       func7,
    input  logic [31:0]      imm,
    input  logic [4:0]       reg_source_0,
    input  logic [4:0]       reg_source_1,
    input  logic [4:0]       reg_dest,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instruction,
    output logic             fmt_err,
    output logic             range_err,
    output logic [CNT_W-1:0] enc_count
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    typedef enum logic [2:0] {FMT_I, FMT_R, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

    typedef struct packed {
        logic [31:0] word;
        logic        fmt_err;
        logic        range_err;
    } entry_t;

    fmt_e        fmt;
    logic [31:0] packed_word;
    logic        push_rng;

    entry_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop;

    always_comb begin
        fmt = FMT_BAD;
        case (opcode)
            OPC_JALR, OPC_LOAD, OPC_OP_IMM: fmt = FMT_I;
            OPC_OP:                         fmt = FMT_R;
            OPC_STORE:                      fmt = FMT_S;
            OPC_BRANCH:                     fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:             fmt = FMT_U;
            OPC_JAL:                        fmt = FMT_J;
            default:                        fmt = FMT_BAD;
        endcase
    end

    // Unsupported opcodes fall back to R-type layout so the word is still deterministic.
    always_comb begin
        packed_word = {func7, reg_source_1, reg_source_0, func3, reg_dest, opcode};
        case (fmt)
            FMT_I: packed_word = {imm[11:0], reg_source_0, func3, reg_dest, opcode};
            FMT_S: packed_word = {imm[11:5], reg_source_1, reg_source_0, func3, imm[4:0], opcode};
            FMT_B: packed_word = {imm[12], imm[10:5], reg_source_1, reg_source_0, func3,
                                  imm[4:1], imm[11], opcode};
            FMT_U: packed_word = {imm[31:12], reg_dest, opcode};
            FMT_J: packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], reg_dest, opcode};
            default: packed_word = {func7, reg_source_1, reg_source_0, func3, reg_dest, opcode};
        endcase
    end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    // Flags immediates whose dropped bits would change the decoded value.
    always_comb begin
        push_rng = 1'b0;
        case (fmt)
            FMT_I, FMT_S: push_rng = !((&imm[31:11]) || !(|imm[31:11]));
            FMT_B:        push_rng = imm[0] || !((&imm[31:12]) || !(|imm[31:12]));
            FMT_J:        push_rng = imm[0] || !((&imm[31:20]) || !(|imm[31:20]));
            FMT_U:        push_rng = |imm[11:0];
            default:      push_rng = 1'b0;
        endcase
    end
`else
    assign push_rng = 1'b0;
`endif

    assign in_ready  = (count != (AW+1)'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            enc_count <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{word: packed_word, fmt_err: (fmt == FMT_BAD), range_err: push_rng};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                if (enc_count != '1) enc_count <= enc_count + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Head is storage output; zeroed while empty so idle outputs match reset values.
    assign instruction = out_valid ? mem[rd_ptr].word      : '0;
    assign fmt_err     = out_valid ? mem[rd_ptr].fmt_err   : 1'b0;
    assign range_err   = out_valid ? mem[rd_ptr].range_err : 1'b0;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: driver queues expected words, negedge monitor checks pops.
module tb_instr_encoder;
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [6:0]  opcode, func7;
    logic [2:0]  func3;
    logic [31:0] imm;
    logic [4:0]  reg_source_0, reg_source_1, reg_dest;
    logic        out_valid, out_ready;
    logic [31:0] instruction;
    logic        fmt_err, range_err;
    logic [15:0] enc_count;

    typedef struct {
        logic [31:0] word;
        logic        fe;
        logic        re;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   exp_cnt = 0;

    instr_encoder #(.DEPTH(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .func3(func3), .func7(func7), .imm(imm),
        .reg_source_0(reg_source_0), .reg_source_1(reg_source_1), .reg_dest(reg_dest),
        .out_valid(out_valid), .out_ready(out_ready), .instruction(instruction),
        .fmt_err(fmt_err), .range_err(range_err), .enc_count(enc_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called just after a posedge; returns just after the accepting posedge.
    task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] im, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] ew, input bit ef, input bit er);
        int budget = 50;
        opcode = opc; func3 = f3; func7 = f7; imm = im;
        reg_source_0 = rs1; reg_source_1 = rs2; reg_dest = rd;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            budget--;
            if (budget == 0) begin
                chk("send_timeout", 32'd1, 32'd0);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        sb.push_back('{word: ew, fe: ef, re: er});
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget = 50;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
        #1;
    endtask

    // Monitor: pops the scoreboard on each handshake and checks head stability while stalled.
    initial begin
        bit          stall_prev = 1'b0;
        logic [31:0] prev_instr = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stall_prev = 1'b0;
                continue;
            end
            chk("enc_count", 32'(enc_count), 32'(exp_cnt));
            if (out_valid && stall_prev) chk("head_stable", instruction, prev_instr);
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("instruction", instruction, e.word);
                    chk("fmt_err", 32'(fmt_err), 32'(e.fe));
                    chk("range_err", 32'(range_err), 32'(e.re));
                end
                exp_cnt++;
            end
            stall_prev = out_valid && !out_ready;
            prev_instr = instruction;
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        opcode = '0; func3 = '0; func7 = '0; imm = '0;
        reg_source_0 = '0; reg_source_1 = '0; reg_dest = '0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_instruction", instruction, 32'd0);
        chk("rst_enc_count", 32'(enc_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // ADDI x1,x0,5: visible the cycle after acceptance
        send(7'b0010011, 3'd0, 7'd0, 32'd5, 5'd0, 5'd0, 5'd1, 32'h00500093, 1'b0, 1'b0);
        @(negedge clk);
        chk("latency_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // SW x2,8(x1) then BEQ x0,x0,-4 back to back
        send(7'b0100011, 3'd2, 7'd0, 32'd8, 5'd1, 5'd2, 5'd0, 32'h0020A423, 1'b0, 1'b0);
        send(7'b1100011, 3'd0, 7'd0, 32'hFFFFFFFC, 5'd0, 5'd0, 5'd0, 32'hFE000EE3, 1'b0, 1'b0);
        // JAL x1,+8 and LUI x5,0x12345
        send(7'b1101111, 3'd0, 7'd0, 32'd8, 5'd0, 5'd0, 5'd1, 32'h008000EF, 1'b0, 1'b0);
        send(7'b0110111, 3'd0, 7'd0, 32'h12345000, 5'd0, 5'd0, 5'd5, 32'h123452B7, 1'b0, 1'b0);
        // Unsupported opcode packs as R-type
        send(7'b1111111, 3'd5, 7'h20, 32'hFFFFFFFF, 5'd2, 5'd3, 5'd4, 32'h4031527F, 1'b1, 1'b0);
        // ADDI with imm 0x800: truncated, range flagged only with the check built in
        send(7'b0010011, 3'd0, 7'd0, 32'h00000800, 5'd0, 5'd0, 5'd0, 32'h80000013, 1'b0, RC);
        drain();

        // Backpressure: fill the FIFO, hold the head, then release
        out_ready = 1'b0;
        send(7'b0010011, 3'd0, 7'd0, 32'd1, 5'd0, 5'd0, 5'd2, 32'h00100113, 1'b0, 1'b0);
        send(7'b0010011, 3'd0, 7'd0, 32'd2, 5'd0, 5'd0, 5'd3, 32'h00200193, 1'b0, 1'b0);
        @(negedge clk);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_head", instruction, 32'h00100113);
        fork
            send(7'b0010011, 3'd0, 7'd0, 32'd3, 5'd0, 5'd0, 5'd4, 32'h00300213, 1'b0, 1'b0);
            begin
                repeat (3) @(negedge clk);
                chk("stalled_in_ready", 32'(in_ready), 32'd0);
                @(posedge clk); #1 out_ready = 1'b1;
                @(negedge clk);
                @(negedge clk);
                chk("ready_after_pop", 32'(in_ready), 32'd1);
            end
        join
        drain();

        // Reset with two entries queued
        out_ready = 1'b0;
        send(7'b0010011, 3'd0, 7'd0, 32'd1, 5'd0, 5'd0, 5'd2, 32'h00100113, 1'b0, 1'b0);
        send(7'b0010011, 3'd0, 7'd0, 32'd2, 5'd0, 5'd0, 5'd3, 32'h00200193, 1'b0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_instruction", instruction, 32'd0);
        chk("midrst_fmt_err", 32'(fmt_err), 32'd0);
        sb.delete();
        exp_cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        chk("postrst_enc_count", 32'(enc_count), 32'd0);
        chk("postrst_in_ready", 32'(in_ready), 32'd1);
        chk("postrst_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        send(7'b0010011, 3'd0, 7'd0, 32'd5, 5'd0, 5'd0, 5'd1, 32'h00500093, 1'b0, 1'b0);
        drain();
        @(negedge clk);
        chk("final_enc_count", 32'(enc_count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Packs RISC-V RV32I instruction fields into a 32-bit instruction word. It is the inverse of the core's field decoder.
- Used by the self-test/boot injector and by the verification loopback: encoded words feed the decoder, and decoded fields must round-trip.
- Field bundles are accepted on a valid/ready input, packed by opcode format, and buffered in a small FIFO.
- Words are emitted on a valid/ready output.

Parameters:
- DEPTH, 2, output FIFO entries (power of two, >=2)
- CNT_W, 16, width of the encoded-instruction counter

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  field bundle valid
- in_ready  output  1  encoder can accept a bundle
- opcode  input  7  instruction[6:0]
- func3  input  3  instruction[14:12]
- func7  input  7  instruction[31:25], used for R-type only
- imm  input  32  sign-extended immediate, in decoder convention
- reg_source_0  input  5  rs1, instruction[19:15]
- reg_source_1  input  5  rs2, instruction[24:20]
- reg_dest  input  5  rd, instruction[11:7]
- out_valid  output  1  encoded word available
- out_ready  input  1  consumer accepts the word
- instruction  output  32  encoded word (head of FIFO)
- fmt_err  output  1  head word had an unsupported opcode
- range_err  output  1  head word's imm not representable (see Optional Feature)
- enc_count  output  CNT_W  number of words popped, saturating

Behaviour:
- Reset (async assert, sync deassert by clk) values:
  - FIFO empty; out_valid=0, instruction=0, fmt_err=0, range_err=0, enc_count=0.
  - in_ready=1 in the first cycle after deassert.
- Accept: in_valid && in_ready at a clk edge pushes the packed word plus flags. in_ready = !full; it has no combinational dependence on out_ready.
- Pop: out_valid && out_ready pops the head.
  - out_valid = !empty.
  - instruction/fmt_err/range_err are registered FIFO head contents and hold stable while out_valid && !out_ready.
- Latency: a bundle accepted in cycle N is visible with out_valid=1 in cycle N+1 when the FIFO was empty. No bypass.
- Simultaneous push and pop:
  - Allowed when not full; occupancy is unchanged.
  - When full, the push is blocked (in_ready=0) even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. An occupancy counter of width log2(DEPTH)+1 distinguishes full from empty.
- Packing by opcode; the low 7 bits are always opcode:
  - I (1100111 JALR, 0000011 LOAD, 0010011 OP_IMM): {imm[11:0], rs1, func3, rd, opcode}.
  - R (0110011 OP): {func7, rs2, rs1, func3, rd, opcode}.
  - S (0100011 STORE): {imm[11:5], rs2, rs1, func3, imm[4:0], opcode}.
  - B (1100011 BRANCH): {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode}.
  - U (0110111 LUI, 0010111 AUIPC): {imm[31:12], rd, opcode}.
  - J (1101111 JAL): {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
  - Any other opcode: packed as R-type, fmt_err=1 for that entry.
- Immediate bits outside the format field are ignored for packing.
- enc_count increments by 1 on each pop and saturates at all-ones.
- Reset asserted mid-transfer discards all FIFO contents immediately and forces all outputs to reset values.

Optional Feature:
- Macro: INSTR_ENCODER_RANGE_CHECK_EN.
- Defined: range_err is computed per entry at push time:
  - I/S: imm[31:11] must be all equal.
  - B: imm[0]==0 and imm[31:12] all equal.
  - J: imm[0]==0 and imm[31:20] all equal.
  - U: imm[11:0]==0.
  - R/unsupported: range_err=0.
  - The word is still packed (truncated) and emitted; range_err only flags it.
- Undefined: range_err is tied to 0 and no check logic is present.

Test Plan:
- ADDI x1,x0,5 (opcode 0010011, func3 0, rd 1, rs1 0, imm 5), out_ready=1 -> out_valid next cycle, instruction=0x00500093, fmt_err=0, enc_count=1.
- SW x2,8(x1), then BEQ x0,x0,-4 (imm 0xFFFFFFFC) back-to-back -> 0x0020A423, then 0xFE000EE3, in order.
- JAL x1,+8 and LUI x5 with imm 0x12345000 -> 0x008000EF and 0x123452B7.
- Full/backpressure: out_ready=0, push 3 bundles with DEPTH=2 -> in_ready=0 after 2 pushes and the head holds stable. Then out_ready=1 -> words pop in order, with in_ready=1 the cycle after the first pop.
- Opcode 1111111 -> fmt_err=1, R-type packing. With the macro defined, ADDI imm 0x00000800 -> range_err=1, instruction=0x80000013 (rd=0, rs1=0).
- Assert rst_n=0 with 2 entries queued -> out_valid=0 and instruction=0 immediately; after release, enc_count=0 and in_ready=1.
